// File: rtl/thread_swap_scheduler.sv
// Round-robin hardware thread scheduler: time-slices NUM_THREADS contexts, drains the pipeline, then swaps PC.
// Optional HW_SCHED_STATS_EN adds a 32-bit swap_count output counting swap_pc strobes.
module thread_swap_scheduler #(
   parameter int          NUM_THREADS = 2,
   parameter int          QUANTUM     = 1024,
   parameter logic [31:0] BOOT_PC     = 32'h6000_0000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           sched_en,
   input  logic [NUM_THREADS-1:0]         thread_en,
   input  logic                           commit_valid,
   input  logic [31:0]                    commit_next_pc,
   input  logic                           rob_empty,
   input  logic                           flush,
   output logic                           drain_req,
   output logic                           swap_pc,
   output logic [31:0]                    swap_target_pc,
   output logic [$clog2(NUM_THREADS)-1:0] active_tid
`ifdef HW_SCHED_STATS_EN
   ,output logic [31:0]                   swap_count
`endif
);

   localparam int TID_W = $clog2(NUM_THREADS);
   localparam int CNT_W = $clog2(QUANTUM);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_SWAP  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TID_W-1:0] tid_q, tid_d;
   logic [31:0]      ctx_pc_q [NUM_THREADS];
   logic [31:0]      ctx_pc_d [NUM_THREADS];

   logic [TID_W-1:0] next_tid;
   logic [TID_W-1:0] scan_tid;
   logic             other_en;
   logic             slice_end;

   // Scan from farthest to nearest so the closest enabled successor wins.
   always_comb begin
      next_tid = tid_q;
      other_en = 1'b0;
      scan_tid = tid_q;
      for (int k = NUM_THREADS - 1; k >= 1; k--) begin
         scan_tid = TID_W'((int'(tid_q) + k) % NUM_THREADS);
         if (thread_en[scan_tid]) begin
            next_tid = scan_tid;
            other_en = 1'b1;
         end
      end
   end

   // A disabled active thread ends its slice early, same as quantum expiry.
   assign slice_end = (cnt_q == CNT_LAST) || !thread_en[tid_q];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tid_d    = tid_q;
      ctx_pc_d = ctx_pc_q;

      if (commit_valid && (state_q == ST_RUN || state_q == ST_DRAIN)) begin
         ctx_pc_d[tid_q] = commit_next_pc;
      end

      case (state_q)
         ST_RUN: begin
            if (!sched_en) begin
               cnt_d = '0;
            end else if (slice_end && other_en) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (!sched_en) begin
               state_d = ST_RUN;
            end else if (rob_empty && !flush) begin
               state_d = ST_SWAP;
            end
         end
         ST_SWAP: begin
            state_d = ST_RUN;
            tid_d   = next_tid;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         tid_q   <= '0;
         for (int i = 0; i < NUM_THREADS; i++) begin
            ctx_pc_q[i] <= BOOT_PC + 32'(i) * 32'h0010_0000;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tid_q    <= tid_d;
         ctx_pc_q <= ctx_pc_d;
      end
   end

   assign drain_req      = (state_q == ST_DRAIN) || (state_q == ST_SWAP);
   // Reset in the SWAP cycle must suppress the strobe immediately.
   assign swap_pc        = (state_q == ST_SWAP) && !rst;
   assign swap_target_pc = (state_q == ST_SWAP) ? ctx_pc_q[next_tid] : ctx_pc_q[tid_q];
   assign active_tid     = tid_q;

`ifdef HW_SCHED_STATS_EN
   logic [31:0] swap_count_q, swap_count_d;

   always_comb begin
      swap_count_d = swap_count_q + {31'd0, swap_pc};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         swap_count_q <= '0;
      end else begin
         swap_count_q <= swap_count_d;
      end
   end

   assign swap_count = swap_count_q;
`endif

endmodule
